// File: rtl/fp_pkg.sv
// Shared single-precision types and constants for the adder front end.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SIG_W = MAN_W + 4;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp_t;

    typedef enum logic [2:0] {
        ZERO,
        SUBNORMAL,
        NORMAL,
        INF,
        NAN
    } fp_class_e;

endpackage

// File: rtl/fp_align_shift_sticky.sv
// Logarithmic right shifter; every bit shifted off the end is folded
// into bit 0 so the sticky bit survives any shift distance.
module fp_align_shift_sticky #(
    parameter int SIG_W = 27,
    parameter int D_W   = 8
) (
    input  logic [SIG_W-1:0] sig,
    input  logic [D_W-1:0]   d,
    output logic [SIG_W-1:0] shifted
);

    localparam int LOG = $clog2(SIG_W);

    logic [LOG:0][SIG_W-1:0] stg;

    assign stg[0] = sig;

    for (genvar i = 0; i < LOG; i++) begin : g_stage
        localparam logic [SIG_W-1:0] MASK =
            SIG_W'((64'd1 << (1 << i)) - 64'd1);
        logic lost;
        assign lost = |(stg[i] & MASK);
        assign stg[i+1] = d[i] ?
            ((stg[i] >> (1 << i)) | SIG_W'(lost)) : stg[i];
    end

    // Any high distance bit puts d past the significand width.
    if (D_W > LOG) begin : g_far
        assign shifted = (|d[D_W-1:LOG]) ?
            {{(SIG_W-1){1'b0}}, |sig} : stg[LOG];
    end else begin : g_near
        assign shifted = stg[LOG];
    end

endmodule

// File: rtl/fp_add_align.sv
// Two-stage alignment front end of the single-precision adder.
// Subnormal operands are kept only when FP_ALIGN_SUBNORMAL_EN is defined.
module fp_add_align #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iValid,
    output logic                     oReady,
    input  logic [EXP_W+MAN_W:0]     iA,
    input  logic [EXP_W+MAN_W:0]     iB,
    input  logic                     iSub,
    output logic                     oValid,
    input  logic                     iReady,
    output logic [EXP_W-1:0]         oExp,
    output logic [MAN_W+3:0]         oManL,
    output logic [MAN_W+3:0]         oManS,
    output logic                     oSign,
    output logic                     oEffSub,
    output logic                     oSpecial,
    output logic [EXP_W+MAN_W:0]     oSpecialRes
);

    import fp_pkg::*;

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;

    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [W-1:0] QNAN_V =
        {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic fp_class_e classify(
        input logic [EXP_W-1:0] e,
        input logic [MAN_W-1:0] f
    );
        fp_class_e c;
        unique case (1'b1)
            (e == '0)   && (f == '0): c = ZERO;
            (e == '0)   && (f != '0): c = SUBNORMAL;
            (e == EMAX) && (f == '0): c = INF;
            (e == EMAX) && (f != '0): c = NAN;
            default:                  c = NORMAL;
        endcase
        return c;
    endfunction

    function automatic logic [EXP_W-1:0] eff_exp(
        input fp_class_e        c,
        input logic [EXP_W-1:0] e
    );
`ifdef FP_ALIGN_SUBNORMAL_EN
        return (c == SUBNORMAL) ? EXP_W'(1) : e;
`else
        return (c == SUBNORMAL) ? '0 : e;
`endif
    endfunction

    function automatic logic [SW-1:0] eff_sig(
        input fp_class_e        c,
        input logic [MAN_W-1:0] f
    );
        logic [MAN_W-1:0] fe;
`ifdef FP_ALIGN_SUBNORMAL_EN
        fe = (c == NORMAL || c == SUBNORMAL) ? f : '0;
`else
        fe = (c == NORMAL) ? f : '0;
`endif
        return {c == NORMAL, fe, 3'b000};
    endfunction

    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb, xa, xb, x_l, x_s;
    logic [MAN_W-1:0] fa, fb;
    logic [SW-1:0]    ma, mb, m_l, m_s;
    fp_class_e        ca, cb;
    logic             a_big, sign_l, eff_sub, is_nan, is_inf;
    logic [W-1:0]     spec_res;

    assign {sa, ea, fa} = iA;
    assign sb = iB[W-1] ^ iSub;
    assign eb = iB[W-2:MAN_W];
    assign fb = iB[MAN_W-1:0];

    assign ca = classify(ea, fa);
    assign cb = classify(eb, fb);
    assign xa = eff_exp(ca, ea);
    assign xb = eff_exp(cb, eb);
    assign ma = eff_sig(ca, fa);
    assign mb = eff_sig(cb, fb);

    // Ties keep A as the larger operand.
    assign a_big  = {xa, ma} >= {xb, mb};
    assign x_l    = a_big ? xa : xb;
    assign x_s    = a_big ? xb : xa;
    assign m_l    = a_big ? ma : mb;
    assign m_s    = a_big ? mb : ma;
    assign sign_l = a_big ? sa : sb;

    assign eff_sub = sa ^ sb;
    assign is_nan  = (ca == NAN) || (cb == NAN) ||
                     ((ca == INF) && (cb == INF) && eff_sub);
    assign is_inf  = (ca == INF) || (cb == INF);
    assign spec_res = is_nan ? QNAN_V : {sign_l, EMAX, {MAN_W{1'b0}}};

    logic s1_valid, s2_valid;
    logic s1_load, s2_load, s1_advance;

    assign s2_load    = !s2_valid || iReady;
    assign s1_advance = s1_valid && s2_load;
    assign s1_load    = !s1_valid || s1_advance;
    assign oReady     = s1_load;
    assign oValid     = s2_valid;

    logic [EXP_W-1:0] s1_exp, s1_d;
    logic [SW-1:0]    s1_man_l, s1_man_s;
    logic             s1_sign, s1_eff_sub, s1_special;
    logic [W-1:0]     s1_spec_res;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            s1_valid    <= 1'b0;
            s1_exp      <= '0;
            s1_d        <= '0;
            s1_man_l    <= '0;
            s1_man_s    <= '0;
            s1_sign     <= 1'b0;
            s1_eff_sub  <= 1'b0;
            s1_special  <= 1'b0;
            s1_spec_res <= '0;
        end else if (s1_load) begin
            s1_valid <= iValid;
            if (iValid) begin
                s1_exp      <= x_l;
                s1_d        <= x_l - x_s;
                s1_man_l    <= m_l;
                s1_man_s    <= m_s;
                s1_sign     <= sign_l;
                s1_eff_sub  <= eff_sub;
                s1_special  <= is_nan || is_inf;
                s1_spec_res <= spec_res;
            end
        end
    end

    logic [SW-1:0] man_s_sh;

    fp_align_shift_sticky #(
        .SIG_W (SW),
        .D_W   (EXP_W)
    ) u_shift (
        .sig     (s1_man_s),
        .d       (s1_d),
        .shifted (man_s_sh)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            s2_valid    <= 1'b0;
            oExp        <= '0;
            oManL       <= '0;
            oManS       <= '0;
            oSign       <= 1'b0;
            oEffSub     <= 1'b0;
            oSpecial    <= 1'b0;
            oSpecialRes <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                oExp        <= s1_special ? '0 : s1_exp;
                oManL       <= s1_special ? '0 : s1_man_l;
                oManS       <= s1_special ? '0 : man_s_sh;
                oSign       <= s1_sign;
                oEffSub     <= s1_eff_sub;
                oSpecial    <= s1_special;
                oSpecialRes <= s1_special ? s1_spec_res : '0;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_align.sv
// Self-checking bench for fp_add_align: directed plan steps plus
// randomized traffic against an arithmetic reference model.
module tb_fp_add_align;

    import fp_pkg::*;

    logic        iClk = 1'b0;
    logic        iRst, iValid, oReady, iSub, oValid, iReady;
    logic        oSign, oEffSub, oSpecial;
    logic [31:0] iA, iB, oSpecialRes;
    logic [7:0]  oExp;
    logic [26:0] oManL, oManS;

    always #5 iClk = ~iClk;

    fp_add_align dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iValid      (iValid),
        .oReady      (oReady),
        .iA          (iA),
        .iB          (iB),
        .iSub        (iSub),
        .oValid      (oValid),
        .iReady      (iReady),
        .oExp        (oExp),
        .oManL       (oManL),
        .oManS       (oManS),
        .oSign       (oSign),
        .oEffSub     (oEffSub),
        .oSpecial    (oSpecial),
        .oSpecialRes (oSpecialRes)
    );

    typedef struct packed {
        logic        special;
        logic [31:0] res;
        logic [7:0]  ex;
        logic [26:0] ml;
        logic [26:0] ms;
        logic        sign;
        logic        effsub;
    } res_t;

    res_t q[$];
    res_t pend;
    bit   pend_v = 0;
    bit   fired;
    int   tests = 0;
    int   fails = 0;

    function automatic res_t mk(input logic [7:0] ex, input logic [26:0] ml,
                                input logic [26:0] ms, input logic s,
                                input logic es);
        res_t r;
        r = '0;
        r.ex = ex; r.ml = ml; r.ms = ms; r.sign = s; r.effsub = es;
        return r;
    endfunction

    function automatic res_t mks(input logic [31:0] res);
        res_t r;
        r = '0;
        r.special = 1'b1;
        r.res = res;
        return r;
    endfunction

    function automatic bit f_nan(input logic [31:0] v);
        return v[30:23] == 8'hFF && v[22:0] != 0;
    endfunction

    function automatic bit f_inf(input logic [31:0] v);
        return v[30:23] == 8'hFF && v[22:0] == 0;
    endfunction

    function automatic void split(input logic [31:0] v, output int x,
                                  output longint unsigned m);
        if (v[30:23] != 0) begin
            x = int'(v[30:23]);
            m = longint'(v[22:0]) + (64'd1 << 23);
        end else begin
`ifdef FP_ALIGN_SUBNORMAL_EN
            x = (v[22:0] != 0) ? 1 : 0;
            m = longint'(v[22:0]);
`else
            x = 0;
            m = 0;
`endif
        end
    endfunction

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub);
        res_t r;
        logic sb, a_l, nan, inf;
        logic [30:0] ka, kb;
        int xa, xb, d;
        longint unsigned ma, mb, ml, ms;
        r = '0;
        sb = b[31] ^ sub;
        ka = a[30:0];
        kb = b[30:0];
`ifndef FP_ALIGN_SUBNORMAL_EN
        if (a[30:23] == 0) ka = 0;
        if (b[30:23] == 0) kb = 0;
`endif
        a_l = ka >= kb;
        r.sign = a_l ? a[31] : sb;
        r.effsub = a[31] ^ sb;
        nan = f_nan(a) || f_nan(b) || (f_inf(a) && f_inf(b) && r.effsub);
        inf = f_inf(a) || f_inf(b);
        if (nan || inf) begin
            r.special = 1'b1;
            r.res = nan ? QNAN : {r.sign, 8'hFF, 23'h0};
            return r;
        end
        split(a, xa, ma);
        split(b, xb, mb);
        ml = (a_l ? ma : mb) << 3;
        ms = (a_l ? mb : ma) << 3;
        d  = a_l ? xa - xb : xb - xa;
        r.ex = 8'(a_l ? xa : xb);
        r.ml = 27'(ml);
        if (d >= 27) r.ms = 27'(ms != 0);
        else r.ms = 27'((ms >> d) | 64'((ms & ((64'd1 << d) - 1)) != 0));
        return r;
    endfunction

    function automatic logic [31:0] rnd_fp(input int base);
        logic [31:0] v;
        int k, e;
        v = $urandom;
        k = $urandom_range(0, 19);
        if (k == 0) return {v[31], 8'hFF, v[22:0] | 23'h1};
        if (k == 1) return {v[31], 8'hFF, 23'h0};
        if (k == 2) return {v[31], 31'h0};
        if (k == 3) return {v[31], 8'h00, v[22:0] | 23'h1};
        e = base + int'($urandom_range(0, 70)) - 35;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        return {v[31], 8'(e), v[22:0]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic chk_out(input string tag, input res_t e);
        logic [127:0] obs, want;
        if (e.special) begin
            obs  = {oSpecial, oSpecialRes, oExp, oManL, oManS};
            want = {1'b1, e.res, 8'h0, 27'h0, 27'h0};
        end else begin
            obs  = {oSpecial, oExp, oManL, oManS, oSign, oEffSub};
            want = {1'b0, e.ex, e.ml, e.ms, e.sign, e.effsub};
        end
        chk(tag, obs, want);
    endtask

    task automatic cycle(input string tag);
        @(negedge iClk);
        fired = 0;
        if (iRst) begin
            q.delete();
        end else begin
            if (oValid) begin
                chk({tag, "_expected"}, 128'(q.size() > 0), 128'd1);
                if (q.size() > 0) begin
                    chk_out(tag, q[0]);
                    if (iReady) void'(q.pop_front());
                end
            end
            if (iValid && oReady) begin
                fired = 1;
                if (pend_v) begin
                    q.push_back(pend);
                    pend_v = 0;
                end else begin
                    q.push_back(model(iA, iB, iSub));
                end
            end
        end
        @(posedge iClk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        iValid = 0;
        iReady = 1;
        for (int i = 0; i < budget && q.size() > 0; i++) cycle(tag);
        chk({tag, "_drain"}, 128'(q.size()), 128'd0);
    endtask

    task automatic send_d(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic s,
                          input res_t e);
        iA = a; iB = b; iSub = s;
        iValid = 1; iReady = 1;
        pend = e; pend_v = 1;
        cycle(tag);
        chk({tag, "_acc"}, 128'(fired), 128'd1);
        iValid = 0;
        drain(tag, 8);
    endtask

    logic [31:0] ta[4], tb[4];
    logic        ts[4];

    initial begin
        int sent, stall, base;
        bit stalled;

        iRst = 1; iValid = 0; iReady = 1; iSub = 0; iA = 0; iB = 0;
        @(posedge iClk); #1;
        @(posedge iClk); #1;
        iRst = 0;
        chk("reset", {oValid, oReady, oExp, oManL, oManS, oSign, oEffSub,
                      oSpecial, oSpecialRes},
            {1'b0, 1'b1, 8'h0, 27'h0, 27'h0, 3'b000, 32'h0});

        iA = 32'h3F80_0000; iB = 32'h3F80_0000; iSub = 0; iValid = 1;
        pend = mk(8'h7F, 27'h400_0000, 27'h400_0000, 0, 0); pend_v = 1;
        cycle("t1");
        iValid = 0;
        chk("t1_lat1", 128'(oValid), 128'd0);
        cycle("t1");
        chk("t1_lat2", 128'(oValid), 128'd1);
        drain("t1", 4);

        send_d("t2", 32'h3F80_0000, 32'h4000_0000, 1,
               mk(8'h80, 27'h400_0000, 27'h200_0000, 1, 1));
        send_d("t3", 32'h4E80_0000, 32'h3F80_0001, 0,
               mk(8'h9D, 27'h400_0000, 27'h000_0001, 0, 0));
        send_d("t4_nan", 32'h7FC0_0001, 32'h3F80_0000, 0, mks(32'h7FC0_0000));
        send_d("t4_infinf", 32'h7F80_0000, 32'h7F80_0000, 1,
               mks(32'h7FC0_0000));
        send_d("t4_inf", 32'h7F80_0000, 32'h3F80_0000, 0, mks(32'h7F80_0000));
        send_d("t4_ninf", 32'h3F80_0000, 32'h7F80_0000, 1,
               mks(32'hFF80_0000));
        send_d("zero", 32'h0000_0000, 32'h3F80_0000, 0,
               mk(8'h7F, 27'h400_0000, 27'h0, 0, 0));
`ifdef FP_ALIGN_SUBNORMAL_EN
        send_d("subn", 32'h0000_0001, 32'h0000_0001, 0,
               mk(8'h01, 27'h000_0008, 27'h000_0008, 0, 0));
`else
        send_d("subn", 32'h0000_0001, 32'h0000_0001, 0,
               mk(8'h00, 27'h0, 27'h0, 0, 0));
`endif

        for (int i = 0; i < 4; i++) begin
            base = $urandom_range(30, 220);
            ta[i] = {1'b0, 8'(base), 23'($urandom)};
            tb[i] = {1'($urandom), 8'(base - i * 3), 23'($urandom)};
            ts[i] = 1'($urandom);
        end
        sent = 0; stall = 0; stalled = 0;
        for (int c = 0; c < 40 && (sent < 4 || q.size() > 0); c++) begin
            if (!stalled && oValid) begin
                stall = 3;
                stalled = 1;
            end
            iReady = (stall == 0);
            iValid = (sent < 4);
            iA = ta[sent % 4]; iB = tb[sent % 4]; iSub = ts[sent % 4];
            #1;
            if (stall > 0) begin
                chk("t5_ready", 128'(oReady), 128'd0);
                stall--;
            end
            cycle("t5");
            if (fired) sent++;
        end
        chk("t5_sent", 128'(sent), 128'd4);
        drain("t5", 4);

        for (int c = 0; c < 600; c++) begin
            base = $urandom_range(1, 254);
            iA = rnd_fp(base);
            iB = rnd_fp(base);
            iSub = 1'($urandom);
            iValid = ($urandom_range(0, 3) != 0);
            iReady = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end
        drain("rand", 10);

        iReady = 0; iValid = 1;
        iA = 32'h4040_0000; iB = 32'h3F80_0000; iSub = 0;
        cycle("t6");
        cycle("t6");
        cycle("t6");
        chk("t6_full", 128'(oReady), 128'd0);
        iRst = 1;
        cycle("t6");
        iRst = 0; iValid = 0;
        chk("t6_reset", {oValid, oReady, oExp, oManL, oManS, oSign, oEffSub,
                         oSpecial, oSpecialRes},
            {1'b0, 1'b1, 8'h0, 27'h0, 27'h0, 3'b000, 32'h0});
        iReady = 1;
        for (int c = 0; c < 5; c++) begin
            cycle("t6_post");
            chk("t6_drop", 128'(oValid), 128'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
